// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Fetch-stage dynamic branch predictor. Direct-mapped BTB with
//               2-bit saturating direction counters, combinational IF lookup,
//               EX-stage resolution/training, mispredict redirect and
//               saturating performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // Fetch-stage lookup
    input  logic [WIDTH-1:0] pc_IF,
    output logic             pred_taken_IF,
    output logic [WIDTH-1:0] pred_target_IF,
    // Execute-stage resolution
    input  logic             valid_EX,
    input  logic             is_branch_EX,
    input  logic [WIDTH-1:0] pc_EX,
    input  logic             taken_EX,
    input  logic [WIDTH-1:0] target_EX,
    input  logic             pred_taken_EX,
    input  logic [WIDTH-1:0] pred_target_EX,
    output logic             mispredict_EX,
    output logic [WIDTH-1:0] redirect_pc_EX,
    // Performance counters
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispredict_cnt
);

    localparam int               c_idx_w = $clog2(ENTRIES);
    localparam int               c_tag_w = WIDTH - c_idx_w - 2;
    localparam logic [WIDTH-1:0] c_four  = WIDTH'(4);
    localparam logic [1:0]       c_ctr_reset = 2'b01;
    localparam logic [1:0]       c_ctr_alloc = 2'b10;

    // BTB storage
    logic               r_valid  [ENTRIES];
    logic [c_tag_w-1:0] r_tag    [ENTRIES];
    logic [WIDTH-1:0]   r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispredict_cnt;

    // Lookup side
    logic [c_idx_w-1:0] w_if_idx;
    logic [c_tag_w-1:0] w_if_tag;
    logic               w_if_hit;

    // Resolution side
    logic [c_idx_w-1:0] w_ex_idx;
    logic [c_tag_w-1:0] w_ex_tag;
    logic               w_ex_hit;
    logic               w_mispredict;
    logic [WIDTH-1:0]   w_pc_plus4;
    logic               w_branch_inc;

    // Instructions are word aligned, so the low two PC bits carry no information
    logic w_unused_pc_lsbs;
    assign w_unused_pc_lsbs = ^{pc_IF[1:0], pc_EX[1:0]};

    assign w_if_idx = pc_IF[c_idx_w+1:2];
    assign w_if_tag = pc_IF[WIDTH-1:c_idx_w+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    assign pred_taken_IF  = w_if_hit && r_ctr[w_if_idx][1];
    assign pred_target_IF = pred_taken_IF ? r_target[w_if_idx] : '0;

    assign w_ex_idx   = pc_EX[c_idx_w+1:2];
    assign w_ex_tag   = pc_EX[WIDTH-1:c_idx_w+2];
    assign w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_pc_plus4 = pc_EX + c_four;

    // Mispredict detection: wrong direction, wrong taken target, or a
    // non-branch that was steered by a stale BTB entry
    always_comb begin
        w_mispredict = 1'b0;
        if (valid_EX) begin
            if (is_branch_EX) begin
                w_mispredict = (taken_EX != pred_taken_EX) ||
                               (taken_EX && pred_taken_EX && (target_EX != pred_target_EX));
            end else begin
                w_mispredict = pred_taken_EX;
            end
        end
    end

    assign mispredict_EX  = w_mispredict;
    assign redirect_pc_EX = (valid_EX && is_branch_EX && taken_EX) ? target_EX : w_pc_plus4;

    // BTB training from the resolved EX outcome; lookups see old contents this cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_ctr_reset;
            end
        end else if (valid_EX) begin
            if (is_branch_EX) begin
                if (w_ex_hit) begin
                    if (taken_EX) begin
                        if (r_ctr[w_ex_idx] != 2'b11) begin
                            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                        end
                        r_target[w_ex_idx] <= target_EX;
                    end else if (r_ctr[w_ex_idx] != 2'b00) begin
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                    end
                end else if (taken_EX) begin
                    // Allocation evicts whatever occupied the slot
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= target_EX;
                    r_ctr[w_ex_idx]    <= c_ctr_alloc;
                end
            end else if (pred_taken_EX && w_ex_hit) begin
                // Entry predicted a redirect for a non-branch: drop it
                r_valid[w_ex_idx] <= 1'b0;
            end
        end
    end

    assign w_branch_inc = valid_EX && is_branch_EX;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            if (w_branch_inc && (r_branch_cnt != 32'hFFFF_FFFF)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_mispredict && (r_mispredict_cnt != 32'hFFFF_FFFF)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. The IF stage looks up the current PC in the same cycle and gets a predicted-taken flag and target. The EX stage returns the resolved outcome from the branch comparator (its PCSel output) together with the prediction carried down the pipe. The block trains its tables on that outcome, flags mispredictions and supplies the corrective PC.

## Interface
- WIDTH, 32, address/data width
- ENTRIES, 16, BTB entries; power of two, at least 2; IDX = log2(ENTRIES)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pc_IF  in  WIDTH  PC being fetched
- pred_taken_IF  out  1  predicted taken for pc_IF
- pred_target_IF  out  WIDTH  predicted target; 0 when pred_taken_IF=0
- valid_EX  in  1  EX holds a real instruction (0 = bubble)
- is_branch_EX  in  1  EX instruction is B-type, JAL or JALR
- pc_EX  in  WIDTH  PC of EX instruction
- taken_EX  in  1  resolved taken (PCSel)
- target_EX  in  WIDTH  resolved target address
- pred_taken_EX  in  1  prediction made at fetch for this instruction
- pred_target_EX  in  WIDTH  predicted target made at fetch
- mispredict_EX  out  1  flush IF/ID and redirect
- redirect_pc_EX  out  WIDTH  correct next PC
- branch_cnt  out  32  resolved branch/jump count
- mispredict_cnt  out  32  misprediction count

## Operation
- **Entry format:** valid, tag = pc[WIDTH-1:IDX+2], target[WIDTH-1:0], ctr[1:0].
- **Index:** pc[IDX+1:2]. pc[1:0] is ignored.
- **Counter encoding:** 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Lookup (combinational):**
  - hit = valid[idx] && tag match.
  - pred_taken_IF = hit && ctr[1].
  - pred_target_IF = stored target if pred_taken_IF, else 0.
- **Resolution, when valid_EX=1:**
  - mispredict_EX = 1 if any of the following holds:
    - (a) is_branch_EX && taken_EX != pred_taken_EX
    - (b) is_branch_EX && taken_EX && pred_taken_EX && target_EX != pred_target_EX
    - (c) !is_branch_EX && pred_taken_EX
  - redirect_pc_EX = target_EX if is_branch_EX && taken_EX; otherwise pc_EX+4 (modulo 2^WIDTH).
- **valid_EX=0:** mispredict_EX=0, redirect_pc_EX=pc_EX+4, and no table update or count.
- **Training, written at the rising edge when valid_EX=1:**
  - Branch, hit: ctr increments (taken) or decrements (not-taken), saturating at 11 and 00. target <= target_EX if taken.
  - Branch, miss, taken: allocate (overwriting any previous occupant): valid=1, tag, target=target_EX, ctr=10.
  - Branch, miss, not-taken: no change.
  - Non-branch with pred_taken_EX=1 (stale entry): if the entry for pc_EX hits, clear its valid.
- **Perf counters:**
  - branch_cnt increments when valid_EX && is_branch_EX.
  - mispredict_cnt increments when mispredict_EX.
  - Both saturate at 0xFFFF_FFFF.

## Timing
- Lookup outputs and EX outputs are combinational, with zero-cycle latency from their inputs.
- Table writes take effect at the rising edge. A lookup in the same cycle as a write to the same index sees the pre-write contents (no bypass). The new contents are visible from the next cycle.
- One update per cycle at most. One lookup per cycle.
- **Reset (asynchronous assert, any cycle, including mid-update):**
  - All valid=0, all ctr=01, targets/tags=0.
  - branch_cnt=0, mispredict_cnt=0.
  - While reset is held: pred_taken_IF=0, pred_target_IF=0. mispredict_EX and redirect_pc_EX follow their combinational equations.
  - Release is sampled synchronously to clk by the integrator. The first write occurs at the first rising edge with rst_n=1.
- Aliasing between two PCs with the same index but different tags is a miss, never a false hit.

## Test plan
- **Cold start:** after reset, pc_IF=0x100 -> pred_taken_IF=0, pred_target_IF=0; counters read 0.
- **Allocate and predict:** EX branch pc_EX=0x100, taken_EX=1, target_EX=0x80, pred_taken_EX=0 -> mispredict_EX=1, redirect_pc_EX=0x80. Next cycle pc_IF=0x100 -> pred_taken_IF=1, pred_target_IF=0x80. In the same cycle as the write, the lookup still shows 0.
- **Hysteresis:** from ctr=10, resolve 0x100 not-taken twice. First -> ctr=01, pred_taken_IF=0. Second -> ctr=00. One taken -> ctr=01, still predicts not-taken. Three taken from 00 -> ctr=11. Further taken stays at 11.
- **Target change:** entry 0x100 -> 0x80, resolve taken with target_EX=0x200 and pred_target_EX=0x80 -> mispredict_EX=1, redirect_pc_EX=0x200. Next lookup gives target 0x200.
- **Stale entry and alias:** valid_EX=1, is_branch_EX=0, pc_EX=0x100, pred_taken_EX=1 -> mispredict_EX=1, redirect_pc_EX=0x104, entry invalidated. With ENTRIES=16, pc 0x140 (same index as 0x100, different tag) -> miss.
- **Bubble, counters and async reset:** valid_EX=0 with taken_EX=1 -> mispredict_EX=0, no table or count change. Force both counters to 0xFFFF_FFFF and resolve a mispredicting branch -> both stay 0xFFFF_FFFF. Assert rst_n mid-cycle -> all outputs at reset values before the next edge.
